pc_sequencer: RTL
=================

Name: pc_sequencer

Overview:
- Program-counter stage directly downstream of the branch/jump control decoder.
- Consumes `outmux1`/`outmux0`, `jbrnmux` and `wrtdatmux` from that decoder, plus instruction fields, and owns the PC register.
- Resolves sequential, branch, jump, branch-to-register and memory-indirect (`jm`) next-PC selection.
- `jm` is multi-cycle: a small FSM fetches the target from data memory and stalls the core until the read returns.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, `JM_WAIT` cycles before abort; used only with JM_TIMEOUT_EN.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- pc_en  in  1  advance enable; when low the PC and FSM hold.
- outmux1  in  1  next-PC select high bit from branch/jump control.
- outmux0  in  1  next-PC select low bit from branch/jump control.
- jbrnmux  in  1  1 = register-target branch (`brn`).
- wrtdatmux  in  1  1 = link write for `balz`.
- jtype  in  1  1 = current instruction is `j` (splits select 01 between jump and branch).
- imm16  in  16  instruction immediate, signed.
- jidx  in  26  instruction jump index.
- rs_data  in  32  register-file rs read value.
- mem_rdata  in  32  data-memory read data for `jm`.
- mem_rvalid  in  1  mem_rdata valid strobe.
- pc  out  32  current PC, registered.
- pc_plus4  out  32  pc+4, combinational.
- link_we  out  1  link register write enable.
- link_data  out  32  link value (pc+4).
- mem_req  out  1  single-cycle `jm` read request, registered.
- mem_addr  out  32  `jm` read address, registered, held through wait.
- stall  out  1  high while the FSM is not in RUN.
- jm_timeout  out  1  one-cycle abort pulse; only with JM_TIMEOUT_EN, tied 0 otherwise.

Behaviour:
- Reset (async, any state):
  - pc=RESET_PC, state=RUN.
  - mem_req=0, mem_addr=0, jm_timeout=0, timeout counter=0.
  - stall=0.
- Arithmetic is 32-bit, modulo 2^32; wrap from 32'hFFFF_FFFC to 0 is legal.
  - pc_plus4 = pc+4.
  - btarget = pc_plus4 + (sext(imm16)<<2).
  - jtarget = {pc_plus4[31:28], jidx, 2'b00}.
- RUN, pc_en=1: pc is updated on the next clock edge according to sel={outmux1,outmux0}:
  - 00: pc_plus4.
  - 11: btarget.
  - 01, jbrnmux=1: {rs_data[31:2], 2'b00} (low bits forced to 0).
  - 01, jbrnmux=0, jtype=1: jtarget.
  - 01, jbrnmux=0, jtype=0: btarget.
  - 10: pc unchanged; mem_addr <= rs_data + sext(imm16); mem_req <= 1; go to JM_WAIT.
- RUN, pc_en=0: everything holds; link_we=0.
- link_we = wrtdatmux & pc_en & (state==RUN), combinational; link_data = pc_plus4 always.
- JM_WAIT:
  - stall=1; mem_req drops to 0 after its first cycle.
  - pc_en is ignored.
  - On mem_rvalid: pc <= {mem_rdata[31:2], 2'b00}, go to RUN; stall falls the following cycle.
  - mem_rvalid in the same cycle mem_req is high is accepted.
- mem_rvalid while in RUN is ignored.
- Only one `jm` is outstanding at a time; a new select 10 is evaluated only after returning to RUN.

Optional Feature:
- Macro: JM_TIMEOUT_EN.
- Defined:
  - Counter clears on JM_WAIT entry and increments each JM_WAIT cycle without mem_rvalid.
  - When the count reaches TIMEOUT_CYCLES: pc <= pc+4 (skip the `jm`), jm_timeout pulses for 1 cycle, go to RUN.
  - If mem_rvalid arrives in the same cycle the count hits TIMEOUT_CYCLES, mem_rvalid wins.
- Undefined: no counter; JM_WAIT waits indefinitely; jm_timeout is tied to 0.

Test Plan:
- Reset: RESET_PC=0x100, pulse rst mid-cycle -> pc=0x100 immediately, stall=0, mem_req=0; sel=00 with pc_en for 3 cycles -> pc 0x104, 0x108, 0x10C.
- Branch back: pc=0x200, sel=11, imm16=0xFFFF -> pc=0x200; jtype=1, sel=01, jidx=0x40 -> pc=0x0000_0100.
- brn and balz: sel=01, jbrnmux=1, rs_data=0x1237 -> pc=0x1234; wrtdatmux=1 at pc=0x300 -> link_we=1, link_data=0x304.
- jm: rs_data=0x80, imm16=4, sel=10 -> mem_req=1 for 1 cycle, mem_addr=0x84, stall=1; mem_rvalid after 3 cycles with rdata=0x4002 -> pc=0x4000, stall=0.
- Reset during JM_WAIT -> pc=RESET_PC, state RUN, mem_req=0; a late mem_rvalid is then ignored.
- JM_TIMEOUT_EN, TIMEOUT_CYCLES=4, `jm` at pc=0x500 with no mem_rvalid -> after 4 wait cycles pc=0x504, jm_timeout pulses once.

Source files
------------

// File: rtl/pc_sequencer.sv
// Program-counter stage: sequential/branch/jump/brn next-PC selection plus a
// memory-indirect `jm` fetch FSM. Optional `jm` abort timer under JM_TIMEOUT_EN.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_en,
  input  logic        outmux1,
  input  logic        outmux0,
  input  logic        jbrnmux,
  input  logic        wrtdatmux,
  input  logic        jtype,
  input  logic [15:0] imm16,
  input  logic [25:0] jidx,
  input  logic [31:0] rs_data,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        link_we,
  output logic [31:0] link_data,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic        stall,
  output logic        jm_timeout
);

  localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [0:0] {
    RUN     = 1'b0,
    JM_WAIT = 1'b1
  } state_t;

  state_t      state, state_d;
  logic [31:0] pc_d;
  logic        mem_req_d;
  logic [31:0] mem_addr_d;
  logic [31:0] imm_sext;
  logic [31:0] btarget;
  logic [31:0] jtarget;
  logic [1:0]  sel;
  logic        tmo_hit;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("pc_sequencer: TIMEOUT_CYCLES must be nonzero");
  end

  assign sel       = {outmux1, outmux0};
  assign imm_sext  = {{16{imm16[15]}}, imm16};
  assign pc_plus4  = pc + 32'd4;
  assign btarget   = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign jtarget   = {pc_plus4[31:28], jidx, 2'b00};
  assign link_data = pc_plus4;
  assign link_we   = wrtdatmux & pc_en & (state == RUN);
  assign stall     = (state != RUN);

  // State, PC and jm request registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      pc       <= RESET_PC;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
    end else begin
      state    <= state_d;
      pc       <= pc_d;
      mem_req  <= mem_req_d;
      mem_addr <= mem_addr_d;
    end
  end

  // Next-state and next-PC selection
  always_comb begin
    state_d    = state;
    pc_d       = pc;
    mem_req_d  = 1'b0;
    mem_addr_d = mem_addr;
    case (state)
      RUN: begin
        if (pc_en) begin
          case (sel)
            2'b00: pc_d = pc_plus4;
            2'b11: pc_d = btarget;
            2'b01: begin
              if (jbrnmux)    pc_d = rs_data & ALIGN_MASK;
              else if (jtype) pc_d = jtarget;
              else            pc_d = btarget;
            end
            default: begin
              mem_addr_d = rs_data + imm_sext;
              mem_req_d  = 1'b1;
              state_d    = JM_WAIT;
            end
          endcase
        end
      end
      JM_WAIT: begin
        // Read data beats the abort when both land in the same cycle
        if (mem_rvalid) begin
          pc_d    = mem_rdata & ALIGN_MASK;
          state_d = RUN;
        end else if (tmo_hit) begin
          pc_d    = pc_plus4;
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

`ifdef JM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] tmo_cnt;

  // Counts JM_WAIT cycles without read data; held at zero while running
  assign tmo_hit = (state == JM_WAIT) && !mem_rvalid &&
                   ((32'(tmo_cnt) + 32'd1) == TIMEOUT_CYCLES);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt    <= '0;
      jm_timeout <= 1'b0;
    end else begin
      jm_timeout <= tmo_hit;
      if (state == RUN)     tmo_cnt <= '0;
      else if (!mem_rvalid) tmo_cnt <= tmo_cnt + CNT_W'(1);
    end
  end
`else
  assign tmo_hit    = 1'b0;
  assign jm_timeout = 1'b0;
`endif

endmodule
